// File: rtl/decode_prefix_buffer_pkg.sv
// Shared constants and types for the byte-serial instruction decode front end.
//   - prefix / escape byte values
//   - segment override codes (seg_e)
//   - front-end FSM states (state_e)
//   - body / total length limits
//   - decoded prefix flag bundle (pfx_flags_t)
package decode_prefix_buffer_pkg;

  localparam logic [7:0] PFX_OPSIZE   = 8'h66;
  localparam logic [7:0] PFX_ADDRSIZE = 8'h67;
  localparam logic [7:0] PFX_LOCK     = 8'hF0;
  localparam logic [7:0] PFX_REP      = 8'hF3;
  localparam logic [7:0] PFX_REPNE    = 8'hF2;
  localparam logic [7:0] PFX_SEG_ES   = 8'h26;
  localparam logic [7:0] PFX_SEG_CS   = 8'h2E;
  localparam logic [7:0] PFX_SEG_SS   = 8'h36;
  localparam logic [7:0] PFX_SEG_DS   = 8'h3E;
  localparam logic [7:0] PFX_SEG_FS   = 8'h64;
  localparam logic [7:0] PFX_SEG_GS   = 8'h65;
  localparam logic [7:0] ESCAPE_0F    = 8'h0F;

  typedef enum logic [2:0] {
    SEG_NONE = 3'd0,
    SEG_ES   = 3'd1,
    SEG_CS   = 3'd2,
    SEG_SS   = 3'd3,
    SEG_DS   = 3'd4,
    SEG_FS   = 3'd5,
    SEG_GS   = 3'd6
  } seg_e;

  typedef enum logic [1:0] {
    S_PREFIX = 2'd0,
    S_BODY   = 2'd1,
    S_HOLD   = 2'd2
  } state_e;

  localparam int unsigned MAX_BODY_BYTES  = 9;
  localparam int unsigned MAX_INSTR_BYTES = 15;

  typedef struct packed {
    logic opsize;
    logic addrsize;
    logic lock;
    logic rep;
    logic repne;
  } pfx_flags_t;

endpackage

// File: rtl/decode_prefix_buffer_classify.sv
// prefix_classify: purely combinational classification of one instruction byte.
// Reusable by later decode stages.
//   byte_val  in  8 : byte to classify
//   is_prefix out 1 : byte is a legacy prefix (flag or segment override)
//   flags     out 5 : one-hot decoded prefix flag (all zero if not a flag prefix)
//   seg       out 3 : segment override code, SEG_NONE if not a segment prefix
//   is_escape out 1 : byte is the 0x0F escape
module prefix_classify
  import decode_prefix_buffer_pkg::*;
(
  input  logic [7:0] byte_val,
  output logic       is_prefix,
  output pfx_flags_t flags,
  output seg_e       seg,
  output logic       is_escape
);

  always_comb begin
    flags     = '0;
    seg       = SEG_NONE;
    is_escape = 1'b0;
    case (byte_val)
      PFX_OPSIZE:   flags.opsize   = 1'b1;
      PFX_ADDRSIZE: flags.addrsize = 1'b1;
      PFX_LOCK:     flags.lock     = 1'b1;
      PFX_REP:      flags.rep      = 1'b1;
      PFX_REPNE:    flags.repne    = 1'b1;
      PFX_SEG_ES:   seg            = SEG_ES;
      PFX_SEG_CS:   seg            = SEG_CS;
      PFX_SEG_SS:   seg            = SEG_SS;
      PFX_SEG_DS:   seg            = SEG_DS;
      PFX_SEG_FS:   seg            = SEG_FS;
      PFX_SEG_GS:   seg            = SEG_GS;
      ESCAPE_0F:    is_escape      = 1'b1;
      default:      ;
    endcase
    is_prefix = (|flags) | (seg != SEG_NONE);
  end

endmodule

// File: rtl/decode_prefix_buffer.sv
// decode_prefix_buffer: byte-serial decode front end. Strips legacy prefixes
// and the 0x0F escape, packs up to 9 body bytes little-endian into a 72-bit
// word and presents it with the decoded prefix flags until downstream takes it.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid/in_ready    : byte handshake; in_byte, in_last carry the byte
//   out_valid/out_ready  : instruction handshake
//   unescaped_instr      : body bytes, byte k at [8k+7:8k], unused bytes 0
//   escaped, prefix_*    : decoded escape / prefix flags
//   seg_override         : last segment prefix (SEG_* code)
//   instr_len            : total accepted bytes, saturating at 15
//   err                  : malformed instruction (overlong body/total, no body)
module decode_prefix_buffer
  import decode_prefix_buffer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_byte,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [71:0] unescaped_instr,
  output logic        escaped,
  output logic        prefix_operand_16bit,
  output logic        prefix_address_16bit,
  output logic        prefix_lock,
  output logic        prefix_rep,
  output logic        prefix_repne,
  output logic [2:0]  seg_override,
  output logic [3:0]  instr_len,
  output logic        err
);

  state_e     state, state_next;
  logic       accept, handoff;
  logic       cls_prefix, cls_escape;
  pfx_flags_t cls_flags;
  seg_e       cls_seg;

  logic [71:0] body_q;
  logic [3:0]  body_cnt;
  pfx_flags_t  flags_q;
  seg_e        seg_q;
  logic [3:0]  len_q;
  logic        esc_q;
  logic        err_q;

  prefix_classify u_classify (
    .byte_val  (in_byte),
    .is_prefix (cls_prefix),
    .flags     (cls_flags),
    .seg       (cls_seg),
    .is_escape (cls_escape)
  );

  assign in_ready = (state != S_HOLD);
  assign accept   = in_valid & in_ready;
  assign handoff  = (state == S_HOLD) & out_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= S_PREFIX;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_PREFIX: begin
        if (accept) begin
          if (in_last)          state_next = S_HOLD;
          else if (!cls_prefix) state_next = S_BODY;
        end
      end
      S_BODY:   if (accept && in_last) state_next = S_HOLD;
      S_HOLD:   if (out_ready)         state_next = S_PREFIX;
      default:  state_next = S_PREFIX;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || handoff) begin
      body_q   <= '0;
      body_cnt <= '0;
      flags_q  <= '0;
      seg_q    <= SEG_NONE;
      len_q    <= '0;
      esc_q    <= 1'b0;
      err_q    <= 1'b0;
    end else if (accept) begin
      if (len_q == 4'(MAX_INSTR_BYTES)) err_q <= 1'b1;
      else                              len_q <= len_q + 4'd1;

      if (state == S_PREFIX) begin
        if (cls_prefix) begin
          flags_q <= flags_q | cls_flags;
          if (cls_seg != SEG_NONE) seg_q <= cls_seg;
          if (in_last) err_q <= 1'b1;
        end else if (cls_escape) begin
          esc_q <= 1'b1;
          if (in_last) err_q <= 1'b1;
        end else begin
          body_q[7:0] <= in_byte;
          body_cnt    <= 4'd1;
        end
      end else begin
        // Overflowing body bytes are dropped; the stored body stays intact.
        if (body_cnt == 4'(MAX_BODY_BYTES)) begin
          err_q <= 1'b1;
        end else begin
          for (int unsigned k = 0; k < MAX_BODY_BYTES; k++) begin
            if (body_cnt == 4'(k)) body_q[8*k +: 8] <= in_byte;
          end
          body_cnt <= body_cnt + 4'd1;
        end
      end
    end
  end

  assign out_valid            = (state == S_HOLD);
  assign unescaped_instr      = body_q;
  assign escaped              = esc_q;
  assign prefix_operand_16bit = flags_q.opsize;
  assign prefix_address_16bit = flags_q.addrsize;
  assign prefix_lock          = flags_q.lock;
  assign prefix_rep           = flags_q.rep;
  assign prefix_repne         = flags_q.repne;
  assign seg_override         = seg_q;
  assign instr_len            = len_q;
  assign err                  = err_q;

endmodule

// File: doc/decode_prefix_buffer.md
# decode_prefix_buffer

Byte-serial front end of instruction decode. Accepts one instruction byte per cycle from the trace/fetch stream, strips x86 legacy prefixes and the 0x0F escape, and assembles the remaining body bytes into a 72-bit little-endian word with decoded prefix flags. Sits directly upstream of the operand decoder, which consumes `unescaped_instr`, `prefix_operand_16bit` and `prefix_address_16bit`.

## Interface
- No parameters. Limits are fixed: 9 body bytes, 15 total bytes.
- Clocking (already decided): one clock, `clk`; reset `rst` is synchronous and active-high.
- `clk` in 1: clock.
- `rst` in 1: synchronous active-high reset.
- `in_valid` in 1: `in_byte` is valid this cycle.
- `in_ready` out 1: block accepts a byte this cycle.
- `in_byte` in 8: instruction byte, in program order.
- `in_last` in 1: `in_byte` is the final byte of the instruction.
- `out_valid` out 1: assembled instruction is held on the outputs.
- `out_ready` in 1: downstream consumes the instruction.
- `unescaped_instr` out 72: body bytes; body byte k is at [8k+7:8k]; unused bytes are 0.
- `escaped` out 1: a 0x0F escape preceded the body.
- `prefix_operand_16bit` out 1: 0x66 was seen.
- `prefix_address_16bit` out 1: 0x67 was seen.
- `prefix_lock` out 1: 0xF0 was seen.
- `prefix_rep` out 1: 0xF3 was seen.
- `prefix_repne` out 1: 0xF2 was seen.
- `seg_override` out 3: last segment prefix seen, as a `SEG_*` code; `SEG_NONE` if none was seen.
- `instr_len` out 4: total bytes accepted, including prefixes and escape, saturating at 15.
- `err` out 1: the instruction is malformed (see Operation).

## Operation
- State machine has three states: `S_PREFIX`, `S_BODY`, `S_HOLD`. Reset state is `S_PREFIX`.
- `in_ready` = (state != `S_HOLD`). A byte is accepted when `in_valid & in_ready`.
- Behaviour in `S_PREFIX`, per accepted byte:
  - Prefix byte (66, 67, F0, F2, F3, 26, 2E, 36, 3E, 64, 65): set the matching flag or `seg_override`, then stay.
  - 0x0F: set `escaped`, then go to `S_BODY`.
  - Any other byte: store it as body byte 0, then go to `S_BODY`.
- In `S_BODY`, every byte is stored as the next body byte, including values that match prefixes or 0x0F.
- Duplicate prefixes are legal. Each one counts toward `instr_len`.
- An accepted byte with `in_last=1` moves the state to `S_HOLD` in place of the transition above.
- `err` is set, sticky until handoff, on any of:
  - a 10th or later body byte (the byte is dropped, not stored);
  - a 16th total byte (`instr_len` stays at 15);
  - `in_last` on a byte while still in `S_PREFIX` without a body byte. This covers an escape-only instruction and a prefix-only instruction; in both cases the body is all-zero.
- Handoff happens in `S_HOLD` when `out_valid & out_ready`. All accumulators clear and the state goes to `S_PREFIX`.
- Reset values of outputs: `out_valid`=0, `unescaped_instr`=0, all flags 0, `seg_override`=`SEG_NONE`, `instr_len`=0, `err`=0. `in_ready`=1 from the first cycle after reset.

## Timing
- Throughput is one byte per cycle while not in `S_HOLD`.
- Latency: if the `in_last` byte is accepted in cycle N, `out_valid` is 1 in cycle N+1, and all outputs are registered and stable from N+1 until handoff.
- After handoff in cycle M, `in_ready`=1 in cycle M+1. Minimum gap between instructions is one idle cycle.
- Output fields do not change while `out_valid=1 & out_ready=0`.
- `in_valid` during `S_HOLD` is ignored. The upstream source must hold its byte.
- `rst` asserted mid-instruction or in `S_HOLD` discards all state on the next edge. Reset takes priority over accept and handoff in the same cycle.

## Structure
- Add to `defines.v`:
  - prefix byte constants `PFX_OPSIZE`, `PFX_ADDRSIZE`, `PFX_LOCK`, `PFX_REP`, `PFX_REPNE`, `PFX_SEG_*`, `ESCAPE_0F`;
  - `SEG_NONE`/`SEG_ES`/`SEG_CS`/`SEG_SS`/`SEG_DS`/`SEG_FS`/`SEG_GS` codes;
  - `S_PREFIX`/`S_BODY`/`S_HOLD` encodings;
  - `MAX_BODY_BYTES`=9 and `MAX_INSTR_BYTES`=15.
- One combinational sub-module, `prefix_classify`: input `byte`; outputs `is_prefix`, one-hot flag bits, `seg` code, `is_escape`. It is reusable by later decode stages.

## Test plan
- Bytes 66,01,D8 (last on D8) -> N+1: `unescaped_instr`=0x...00D801, `prefix_operand_16bit`=1, `instr_len`=3, `err`=0.
- Bytes 0F,AF,C3 -> `escaped`=1, `unescaped_instr`[15:0]=0xC3AF, `instr_len`=3.
- Bytes 2E,64,8B,00 -> `seg_override`=`SEG_FS`, body 0x008B. Also hold `out_ready=0` for 5 cycles -> outputs stable and `in_ready`=0 throughout.
- 1 prefix + 10 body bytes (0x90..0x99) -> `err`=1, body holds 0x90..0x98, `instr_len`=11.
- Byte 66 with `in_last` -> `err`=1, body all-zero.
- Assert `rst` after 2 of 4 bytes, then send C3 (last) -> `unescaped_instr`=0xC3, `instr_len`=1, no flags set.
